// File: rtl/mips_reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port
// between ALU writeback (port 0) and load writeback (port 1).
module mips_reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8,
  parameter int ZERO_DROP  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic [ADDR_WIDTH-1:0] reg_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic                  ack_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] reg_1,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic                  ack_1,
  output logic                  signal_reg_write,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  prio;
  logic                  grant_0;
  logic                  grant_1;
  logic                  any_grant;
  logic                  both_req;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_drop;

  // Grant: lone requester wins, ties go to prio; nothing in reset.
  always_comb begin
    grant_0  = 1'b0;
    grant_1  = 1'b0;
    both_req = req_0 & req_1;
    if (!reset) begin
      grant_0 = req_0 & (~req_1 | ~prio);
      grant_1 = req_1 & (~req_0 |  prio);
    end
    any_grant = grant_0 | grant_1;
    sel_reg   = grant_1 ? reg_1  : reg_0;
    sel_data  = grant_1 ? data_1 : data_0;
    sel_drop  = (ZERO_DROP != 0) && (sel_reg == '0);
  end

  assign ack_0 = grant_0;
  assign ack_1 = grant_1;

  // Pointer, issue register and saturating conflict counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio             <= 1'b0;
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
      conflict_count   <= '0;
    end else begin
      if (any_grant) begin
        prio             <= grant_0;
        write_reg        <= sel_reg;
        write_data       <= sel_data;
        signal_reg_write <= ~sel_drop;
      end else begin
        signal_reg_write <= 1'b0;
      end
      if (both_req && conflict_count != CNT_MAX)
        conflict_count <= conflict_count + CNT_ONE;
    end
  end

endmodule
